// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: request/grant/response bundle shared by NUM_CLIENTS
// requesters and the SRAM port arbiter.
//   rd_req/rd_addr/rd_lock : per-client read requests (addresses packed per client)
//   rd_gnt                 : one-hot/zero read grant (combinational)
//   rd_rsp_valid/rd_rsp_data : registered one-hot response tag and shared data
//   wr_req/wr_addr/wr_data : per-client write requests (packed per client)
//   wr_gnt                 : one-hot/zero write grant (combinational)
// Modports: master = client side, slave = arbiter side.
interface sram_port_arbiter_if #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 10
);
    logic [NUM_CLIENTS-1:0]            rd_req;
    logic [NUM_CLIENTS*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_CLIENTS-1:0]            rd_lock;
    logic [NUM_CLIENTS-1:0]            rd_gnt;
    logic [NUM_CLIENTS-1:0]            rd_rsp_valid;
    logic [DATA_WIDTH-1:0]             rd_rsp_data;
    logic [NUM_CLIENTS-1:0]            wr_req;
    logic [NUM_CLIENTS*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_CLIENTS*DATA_WIDTH-1:0] wr_data;
    logic [NUM_CLIENTS-1:0]            wr_gnt;

    modport master (
        output rd_req, rd_addr, rd_lock, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_rsp_valid, rd_rsp_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, rd_lock, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_rsp_valid, rd_rsp_data, wr_gnt
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 1R1W SRAM between NUM_CLIENTS requesters.
// Read and write channels are arbitrated independently by round-robin
// pointers; at most one read and one write are granted per cycle. Read data
// returns one cycle after grant, tagged one-hot to the issuing client.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset (SRAM contents are not cleared)
//   bus   : sram_port_arbiter_if.slave (requests in, grants/responses out)
// Optional feature: define SRAM_ARB_LOCK_EN to let a read client hold its
// grant with rd_lock (IDLE/LOCKED FSM on the read channel).

// Simple 1R1W synchronous SRAM with registered read data.
module sram_1r1w #(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned SIZE              = 1024,
    parameter int unsigned ADDR_WIDTH        = $clog2(SIZE),
    parameter string       READ_DURING_WRITE = "NEW_DATA"
) (
    input  logic                  clk,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);
    localparam bit NEW_DATA = (READ_DURING_WRITE == "NEW_DATA");

    logic [DATA_WIDTH-1:0] mem [SIZE];

    // Same-cycle read of the address being written returns the new word.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
        if (read_en) begin
            if (NEW_DATA && write_en && (write_addr == read_addr)) begin
                read_data <= write_data;
            end else begin
                read_data <= mem[read_addr];
            end
        end
    end
endmodule

module sram_port_arbiter #(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SIZE        = 1024,
    parameter int unsigned ADDR_WIDTH  = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    sram_port_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    // Returns {found, index} of the first requester at or after ptr.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                               input idx_t ptr);
        logic [IDX_W:0]         res;
        logic [NUM_CLIENTS-1:0] sh;
        int unsigned            c;
        res = '0;
        for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
            c  = (32'(ptr) + k) % NUM_CLIENTS;
            sh = req >> c;
            if (!res[IDX_W] && sh[0]) begin
                res = {1'b1, IDX_W'(c)};
            end
        end
        return res;
    endfunction

    function automatic idx_t next_idx(input idx_t g);
        return IDX_W'((32'(g) + 32'd1) % NUM_CLIENTS);
    endfunction

    idx_t                   rd_ptr;
    idx_t                   rd_ptr_next;
    idx_t                   wr_ptr;
    idx_t                   wr_ptr_next;
    idx_t                   rd_sel;
    idx_t                   wr_sel;
    logic                   rd_found;
    logic                   wr_found;
    logic [NUM_CLIENTS-1:0] rd_gnt_c;
    logic [NUM_CLIENTS-1:0] wr_gnt_c;
    logic [NUM_CLIENTS-1:0] rd_rsp_valid;
    logic [DATA_WIDTH-1:0]  rd_rsp_data;
    logic [ADDR_WIDTH-1:0]  rd_addr_c;
    logic [ADDR_WIDTH-1:0]  wr_addr_c;
    logic [DATA_WIDTH-1:0]  wr_data_c;

`ifdef SRAM_ARB_LOCK_EN
    typedef enum logic {IDLE, LOCKED} lock_state_t;

    lock_state_t state;
    lock_state_t state_next;
    idx_t        lock_owner;
    idx_t        lock_owner_next;
`else
    logic unused_rd_lock;
    assign unused_rd_lock = ^bus.rd_lock;
`endif

    // State register: pointers, response tag and (optionally) lock FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            rd_rsp_valid <= '0;
`ifdef SRAM_ARB_LOCK_EN
            state        <= IDLE;
            lock_owner   <= '0;
`endif
        end else begin
            rd_ptr       <= rd_ptr_next;
            wr_ptr       <= wr_ptr_next;
            rd_rsp_valid <= rd_gnt_c;
`ifdef SRAM_ARB_LOCK_EN
            state        <= state_next;
            lock_owner   <= lock_owner_next;
`endif
        end
    end

    // Read channel arbitration and next state.
    always_comb begin
        logic [IDX_W:0] pick;
        idx_t           base;
        logic           holding;
        rd_ptr_next = rd_ptr;
        rd_gnt_c    = '0;
        rd_found    = 1'b0;
        rd_sel      = '0;
        base        = rd_ptr;
        holding     = 1'b0;
        pick        = '0;
`ifdef SRAM_ARB_LOCK_EN
        state_next      = state;
        lock_owner_next = lock_owner;
        // The cycle the owner releases is arbitrated from just past the owner.
        if (state == LOCKED) begin
            if (bus.rd_req[lock_owner] && bus.rd_lock[lock_owner]) begin
                holding = 1'b1;
            end else begin
                state_next  = IDLE;
                base        = next_idx(lock_owner);
                rd_ptr_next = base;
            end
        end
`endif
        if (holding) begin
            rd_found = 1'b1;
            rd_sel   = base;
`ifdef SRAM_ARB_LOCK_EN
            rd_sel   = lock_owner;
`endif
        end else begin
            pick     = rr_pick(bus.rd_req, base);
            rd_found = pick[IDX_W];
            rd_sel   = pick[IDX_W-1:0];
            if (rd_found) begin
                rd_ptr_next = next_idx(rd_sel);
`ifdef SRAM_ARB_LOCK_EN
                if (bus.rd_lock[rd_sel]) begin
                    state_next      = LOCKED;
                    lock_owner_next = rd_sel;
                end
`endif
            end
        end
        if (rd_found && !reset) begin
            rd_gnt_c = NUM_CLIENTS'(1) << rd_sel;
        end
    end

    // Write channel arbitration.
    always_comb begin
        logic [IDX_W:0] pick;
        wr_ptr_next = wr_ptr;
        wr_gnt_c    = '0;
        pick        = rr_pick(bus.wr_req, wr_ptr);
        wr_found    = pick[IDX_W];
        wr_sel      = pick[IDX_W-1:0];
        if (wr_found) begin
            wr_ptr_next = next_idx(wr_sel);
        end
        if (wr_found && !reset) begin
            wr_gnt_c = NUM_CLIENTS'(1) << wr_sel;
        end
    end

    // Granted client's address/data steered to the SRAM ports.
    assign rd_addr_c = ADDR_WIDTH'(bus.rd_addr >> (rd_sel * ADDR_WIDTH));
    assign wr_addr_c = ADDR_WIDTH'(bus.wr_addr >> (wr_sel * ADDR_WIDTH));
    assign wr_data_c = DATA_WIDTH'(bus.wr_data >> (wr_sel * DATA_WIDTH));

    sram_1r1w #(
        .DATA_WIDTH       (DATA_WIDTH),
        .SIZE             (SIZE),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .READ_DURING_WRITE("NEW_DATA")
    ) u_sram (
        .clk       (clk),
        .read_en   (|rd_gnt_c),
        .read_addr (rd_addr_c),
        .read_data (rd_rsp_data),
        .write_en  (|wr_gnt_c),
        .write_addr(wr_addr_c),
        .write_data(wr_data_c)
    );

    assign bus.rd_gnt       = rd_gnt_c;
    assign bus.wr_gnt       = wr_gnt_c;
    assign bus.rd_rsp_valid = rd_rsp_valid;
    assign bus.rd_rsp_data  = rd_rsp_data;
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one `sram_1r1w` instance between NUM_CLIENTS requesters, each with a read channel and a write channel. Each cycle the block grants at most one read and at most one write. The two channels are arbitrated independently with round-robin pointers. Read data returns one cycle after grant, tagged one-hot to the issuing client. It sits between per-lane/per-thread request logic and a shared on-chip buffer.

## Interface
- NUM_CLIENTS, 4, number of requesters (2..16)
- DATA_WIDTH, 32, word width
- SIZE, 1024, words of storage
- ADDR_WIDTH, $clog2(SIZE), word address width
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- rd_req  input  NUM_CLIENTS  per-client read request
- rd_addr  input  NUM_CLIENTS*ADDR_WIDTH  client i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_lock  input  NUM_CLIENTS  hold read grant (used only with SRAM_ARB_LOCK_EN)
- rd_gnt  output  NUM_CLIENTS  one-hot/zero read grant, combinational from requests and state
- rd_rsp_valid  output  NUM_CLIENTS  one-hot/zero, registered; marks response for that client
- rd_rsp_data  output  DATA_WIDTH  shared response data, valid when any rd_rsp_valid bit is set
- wr_req  input  NUM_CLIENTS  per-client write request
- wr_addr  input  NUM_CLIENTS*ADDR_WIDTH  write addresses, packed as rd_addr
- wr_data  input  NUM_CLIENTS*DATA_WIDTH  write data, packed per client
- wr_gnt  output  NUM_CLIENTS  one-hot/zero write grant, combinational

## Operation
- Storage: one internal `sram_1r1w` with READ_DURING_WRITE="NEW_DATA".
- Contents are not cleared by reset.

Read channel:
- rd_ptr is the highest-priority client. Grant goes to the first requesting client scanning rd_ptr, rd_ptr+1, … mod NUM_CLIENTS.
- After a grant to client g, rd_ptr becomes (g+1) mod NUM_CLIENTS.
- With no request, rd_ptr holds.
- A request is accepted in the cycle its gnt bit is high. A client holds req and addr until granted.
- The granted address drives the SRAM read port with read_en=1.

Write channel:
- Same algorithm with an independent wr_ptr.
- The granted client's wr_addr/wr_data drive the SRAM write port with write_en=1.

Responses and hazards:
- rd_rsp_valid is rd_gnt registered.
- rd_rsp_data is the SRAM output.
- Same-cycle read and write grants to the same address return the new data.
- Reset values: rd_ptr=0, wr_ptr=0, rd_rsp_valid=0, lock state=idle. rd_gnt and wr_gnt are 0 whenever reset is high.
- Reset asserted mid-operation drops any in-flight read: no rd_rsp_valid appears after reset deasserts.

## Timing
- Grant latency: 0 cycles (combinational).
- Read response: exactly 1 cycle after grant, with no back-pressure. The client must sample in that cycle.
- Throughput: 1 read plus 1 write per cycle sustained.
- Fairness: a continuously requesting client is granted within NUM_CLIENTS cycles (without lock).
- No combinational path from rd_rsp_* to rd_gnt.

## Configuration
- Macro `SRAM_ARB_LOCK_EN`.
- When defined, the read channel has a 2-state FSM, IDLE and LOCKED.
  - IDLE -> LOCKED when the granted client g has rd_lock[g]=1. Record lock_owner=g.
  - In LOCKED, the grant goes only to lock_owner while rd_req[lock_owner] is high. Other clients get no grant, and rd_ptr does not advance.
  - LOCKED -> IDLE on the first cycle rd_req[lock_owner]&rd_lock[lock_owner] is low. rd_ptr then becomes lock_owner+1 mod NUM_CLIENTS.
  - That same cycle is arbitrated normally.
- When undefined, rd_lock is ignored, there is no FSM, and pure round-robin applies.

## Test plan
- Reset, then client 2 reads addr 5 after a prior write of 0xDEADBEEF -> rd_gnt=4'b0100 at T, rd_rsp_valid=4'b0100 and rd_rsp_data=0xDEADBEEF at T+1.
- All 4 clients request reads continuously from reset -> grants 0,1,2,3,0,… one per cycle, and responses follow one cycle behind each grant.
- Client 1 writes 0x12345678 to addr 9 while client 3 reads addr 9 in the same cycle -> rd_rsp_data=0x12345678 next cycle.
- Clients 0 and 2 write simultaneously -> wr_gnt=0001, then 0100. Memory holds each client's data at its own address.
- Reset asserted the cycle after a read grant -> rd_rsp_valid stays 0. rd_ptr=0, so the next grant with all requesting is client 0.
- With SRAM_ARB_LOCK_EN, client 1 requests with rd_lock=1 for 3 cycles while clients 0, 2 and 3 request -> rd_gnt=0010 for 3 cycles, then 0100 (client 2) once the lock drops.
